mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 47 ++++
 rtl/mem_lsu_load_fmt.sv | 24 ++
 rtl/mem_lsu.sv | 116 +++++++++++
 tb/tb_mem_lsu.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the load/store unit.
//   Memory op-code constants, FSM state enum, the big-endian lane/byte-enable
//   lookup, store-data lane replication, and the ZeroWord/NOPRegAddr constants.
package mem_lsu_pkg;
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr = 5'b00000;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    function automatic logic is_load(input logic [3:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_half(input logic [3:0] op);
        return op inside {OP_LH, OP_LHU, OP_SH};
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return op inside {OP_LW, OP_SW};
    endfunction

    // Big-endian lanes: offset 0 is the most significant byte.
    function automatic logic [3:0] lane_be(input logic [3:0] op, input logic [1:0] off);
        return op inside {OP_LB, OP_LBU, OP_SB} ? 4'b1000 >> off :
               is_half(op) ? (off[1] ? 4'b0011 : 4'b1100) :
               is_word(op) ? 4'b1111 : 4'b0000;
    endfunction

    // Sub-word stores are replicated across all lanes; byte enables select.
    function automatic logic [31:0] st_data(input logic [3:0] op, input logic [31:0] d);
        return op == OP_SB ? {4{d[7:0]}} : op == OP_SH ? {2{d[15:0]}} : d;
    endfunction
endpackage

// File: rtl/mem_lsu_load_fmt.sv
// mem_load_fmt: load formatting -- big-endian lane select plus sign/zero extension.
//   op_i    : memory op code
//   off_i   : byte offset within the word (addr[1:0])
//   rdata_i : raw 32-bit bus word
//   data_o  : formatted 32-bit register value
module mem_load_fmt
    import mem_lsu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);
    logic [7:0]  b;
    logic [15:0] h;
    // Offset 0 sits at [31:24], so shift right by 8*(3-off).
    assign b = 8'(rdata_i >> {~off_i, 3'b000});
    assign h = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    always_comb
        data_o = op_i == OP_LB  ? {{24{b[7]}}, b} :
                 op_i == OP_LBU ? {24'b0, b} :
                 op_i == OP_LH  ? {{16{h[15]}}, h} :
                 op_i == OP_LHU ? {16'b0, h} : rdata_i;
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: pipeline memory stage with a handshaked bus and timeout.
//   Pipeline in : wd_i, wreg_i, wdata_i, mem_op_i, mem_addr_i, reg2_i
//   Pipeline out: wd_o, wreg_o, wdata_o, stallreq_o, bus_err_o
//   Bus         : mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
//                 mem_rdata_i, mem_ack_i
//   rst is asynchronous, active-low.
//   Optional MEM_ALIGN_CHECK_EN: misaligned half/word ops raise bus_err_o
//   in IDLE instead of issuing a request.
module mem_lsu #(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            mem_op_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [31:0]           reg2_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic                  stallreq_o,
    output logic                  bus_err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  mem_ack_i
);
    import mem_lsu_pkg::*;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_q, data_d, fmt;
    logic          err_q, err_d, load, store, mem, mis, req, tmo;

    assign load  = is_load(mem_op_i);
    assign store = is_store(mem_op_i);
    assign mem   = load | store;
`ifdef MEM_ALIGN_CHECK_EN
    assign mis = (is_half(mem_op_i) && mem_addr_i[0]) || (is_word(mem_op_i) && mem_addr_i[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    assign req = (state_q == IDLE && mem && !mis) || state_q == BUSY;
    // The final BUSY cycle still samples ack, so an on-time ack beats the timeout.
    assign tmo = state_q == BUSY && !mem_ack_i && cnt_q == CW'(TIMEOUT - 1);

    mem_load_fmt u_fmt (
        .op_i    (mem_op_i),
        .off_i   (mem_addr_i[1:0]),
        .rdata_i (mem_rdata_i),
        .data_o  (fmt)
    );

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE:    if (req) state_d = mem_ack_i ? DONE : BUSY;
            BUSY:    if (mem_ack_i || tmo) begin
                         state_d = DONE;
                         err_d   = tmo;
                     end
            default: state_d = IDLE;
        endcase
        cnt_d  = (state_q == BUSY && state_d == BUSY) ? cnt_q + 1'b1 : '0;
        data_d = (req && mem_ack_i) ? fmt : data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= ZeroWord;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        wd_o        = wd_i;
        wreg_o      = state_q == DONE ? wreg_i & load & ~err_q : wreg_i & ~mem;
        wdata_o     = (state_q == DONE && load) ? data_q : wdata_i;
        stallreq_o  = req;
        bus_err_o   = state_q == DONE ? err_q : (state_q == IDLE && mis);
        mem_req_o   = req;
        mem_we_o    = req & store;
        mem_addr_o  = req ? {mem_addr_i[ADDR_W-1:2], 2'b00} : '0;
        mem_be_o    = req ? lane_be(mem_op_i, mem_addr_i[1:0]) : 4'b0000;
        mem_wdata_o = (req && store) ? st_data(mem_op_i, reg2_i) : ZeroWord;
        if (!rst) begin
            wd_o        = '0;
            wreg_o      = 1'b0;
            wdata_o     = ZeroWord;
            stallreq_o  = 1'b0;
            bus_err_o   = 1'b0;
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            mem_addr_o  = '0;
            mem_be_o    = 4'b0000;
            mem_wdata_o = ZeroWord;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0, rst = 1'b0;
    logic [4:0]  wd_i = '0, wd_o;
    logic        wreg_i = 1'b0, wreg_o;
    logic [31:0] wdata_i = '0, wdata_o;
    logic [3:0]  mem_op_i = OP_NOP;
    logic [31:0] mem_addr_i = '0, reg2_i = '0, mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        stallreq_o, bus_err_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;

    int vecs = 0, errs = 0, stalls, reqs, errp;

    mem_lsu #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
        .bus_err_o(bus_err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a memory op; ack arrives on stall cycle ack_at (0 = issue cycle, <0 = never).
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] r2,
                         input logic [31:0] rd, input int ack_at);
        mem_op_i = op; mem_addr_i = a; reg2_i = r2; wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'h5555_5555;
        mem_ack_i = ack_at == 0;
        mem_rdata_i = ack_at == 0 ? rd : 32'hDEAD_BEEF;
        #1;
    endtask

    // Run until the stall drops (DONE), counting stall and request cycles.
    task automatic run(input logic [31:0] rd, input int ack_at);
        int cyc = 0;
        stalls = 0; reqs = 0; errp = 0;
        while (stallreq_o && cyc < 40) begin
            stalls++;
            if (mem_req_o) reqs++;
            if (bus_err_o) errp++;
            if (wreg_o) errp++;
            tick();
            cyc++;
            mem_ack_i = cyc == ack_at;
            mem_rdata_i = cyc == ack_at ? rd : 32'hDEAD_BEEF;
            #1;
        end
        chk("run_bounded", 32'(cyc < 40), 32'd1);
        mem_ack_i = 1'b0;
    endtask

    task automatic nop();
        mem_op_i = OP_NOP; mem_ack_i = 1'b0; wreg_i = 1'b0;
    endtask

    initial begin
        wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'hFFFF_0000; mem_op_i = OP_LW; mem_ack_i = 1'b1;
        #2;
        chk("rst_wd", wd_o, 0); chk("rst_wreg", wreg_o, 0); chk("rst_wdata", wdata_o, 0);
        chk("rst_stall", stallreq_o, 0); chk("rst_req", mem_req_o, 0); chk("rst_be", mem_be_o, 0);
        chk("rst_addr", mem_addr_o, 0); chk("rst_we", mem_we_o, 0); chk("rst_err", bus_err_o, 0);
        tick(); tick();
        nop(); rst = 1'b1;
        // NOP pass-through
        wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234;
        #1;
        chk("nop_wd", wd_o, 5); chk("nop_wreg", wreg_o, 1); chk("nop_wdata", wdata_o, 32'h1234);
        chk("nop_stall", stallreq_o, 0); chk("nop_req", mem_req_o, 0);
        tick(); mem_op_i = 4'hF; #1;
        chk("badop_req", mem_req_o, 0); chk("badop_wreg", wreg_o, 1); chk("badop_stall", stallreq_o, 0);
        // LB 0x1001, ack after 3 cycles
        tick(); issue(OP_LB, 32'h1001, 0, 32'h0080_FF00, 3);
        chk("lb_req", mem_req_o, 1); chk("lb_stall", stallreq_o, 1); chk("lb_be", mem_be_o, 4'b0100);
        chk("lb_addr", mem_addr_o, 32'h1000); chk("lb_we", mem_we_o, 0); chk("lb_wreg", wreg_o, 0);
        run(32'h0080_FF00, 3);
        chk("lb_stalls", stalls, 4); chk("lb_reqs", reqs, 4); chk("lb_noerr", errp, 0);
        chk("lb_done_wdata", wdata_o, 32'hFFFF_FF80); chk("lb_done_wreg", wreg_o, 1);
        chk("lb_done_wd", wd_o, 9); chk("lb_done_req", mem_req_o, 0);
        tick(); nop(); #1;
        tick(); issue(OP_LBU, 32'h1001, 0, 32'h0080_FF00, 3);
        run(32'h0080_FF00, 3);
        chk("lbu_stalls", stalls, 4); chk("lbu_wdata", wdata_o, 32'h0000_0080); chk("lbu_wreg", wreg_o, 1);
        tick(); nop(); #1;
        // Halfword loads
        tick(); issue(OP_LH, 32'h6000, 0, 32'h8001_7777, 1);
        chk("lh_be", mem_be_o, 4'b1100);
        run(32'h8001_7777, 1);
        chk("lh_stalls", stalls, 2); chk("lh_wdata", wdata_o, 32'hFFFF_8001);
        tick(); nop(); #1;
        tick(); issue(OP_LHU, 32'h6002, 0, 32'h1234_ABCD, 0);
        chk("lhu_be", mem_be_o, 4'b0011);
        run(32'h1234_ABCD, 0);
        chk("lhu_wdata", wdata_o, 32'h0000_ABCD);
        tick(); nop(); #1;
        // SH 0x2002, immediate ack
        tick(); issue(OP_SH, 32'h2002, 32'hAAAA_BEEF, 0, 0);
        chk("sh_we", mem_we_o, 1); chk("sh_be", mem_be_o, 4'b0011);
        chk("sh_wdata", mem_wdata_o, 32'hBEEF_BEEF); chk("sh_addr", mem_addr_o, 32'h2000);
        run(0, 0);
        chk("sh_stalls", stalls, 1); chk("sh_done_wreg", wreg_o, 0); chk("sh_done_stall", stallreq_o, 0);
        tick(); nop(); #1;
        // SB 0x5003, ack on second cycle
        tick(); issue(OP_SB, 32'h5003, 32'h1234_5678, 0, 1);
        chk("sb_be", mem_be_o, 4'b0001); chk("sb_wdata", mem_wdata_o, 32'h7878_7878);
        run(0, 1);
        chk("sb_stalls", stalls, 2); chk("sb_wreg", wreg_o, 0);
        tick(); nop(); #1;
        // LW timeout
        tick(); issue(OP_LW, 32'h4000, 0, 32'hCAFE_F00D, -1);
        run(32'hCAFE_F00D, -1);
        chk("to_stalls", stalls, 17); chk("to_reqs", reqs, 17); chk("to_noearly", errp, 0);
        chk("to_req_drop", mem_req_o, 0); chk("to_err", bus_err_o, 1); chk("to_wreg", wreg_o, 0);
        tick(); nop(); #1;
        chk("to_err_pulse", bus_err_o, 0);
        // LW ack on 16th BUSY cycle
        tick(); issue(OP_LW, 32'h4000, 0, 32'hCAFE_F00D, 16);
        run(32'hCAFE_F00D, 16);
        chk("ack16_stalls", stalls, 17); chk("ack16_err", bus_err_o, 0);
        chk("ack16_wreg", wreg_o, 1); chk("ack16_wdata", wdata_o, 32'hCAFE_F00D);
        tick(); nop(); #1;
        // Reset during BUSY
        tick(); issue(OP_LW, 32'h4000, 0, 0, -1);
        tick(); tick();
        chk("busy_stall", stallreq_o, 1);
        rst = 1'b0; #1;
        chk("mid_rst_req", mem_req_o, 0); chk("mid_rst_stall", stallreq_o, 0);
        chk("mid_rst_wreg", wreg_o, 0); chk("mid_rst_wd", wd_o, 0);
        chk("mid_rst_wdata", wdata_o, 0); chk("mid_rst_be", mem_be_o, 0);
        tick(); nop(); wreg_i = 1'b1; wdata_i = 32'h77; rst = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_1111; #1;
        chk("post_rst_stall", stallreq_o, 0); chk("post_rst_wdata", wdata_o, 32'h77);
        tick(); #1;
        chk("late_ack_stall", stallreq_o, 0); chk("late_ack_err", bus_err_o, 0); chk("late_ack_wreg", wreg_o, 1);
        mem_ack_i = 1'b0;
        // Misaligned LW 0x3002
        tick(); issue(OP_LW, 32'h3002, 0, 32'h0BAD_0BAD, 0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_req", mem_req_o, 0); chk("mis_err", bus_err_o, 1);
        chk("mis_stall", stallreq_o, 0); chk("mis_wreg", wreg_o, 0);
        tick(); nop(); #1;
        chk("mis_err_pulse", bus_err_o, 0);
`else
        chk("mis_req", mem_req_o, 1); chk("mis_addr", mem_addr_o, 32'h3000);
        chk("mis_be", mem_be_o, 4'b1111); chk("mis_err", bus_err_o, 0);
        run(32'h0BAD_0BAD, 0);
        chk("mis_stalls", stalls, 1); chk("mis_wdata", wdata_o, 32'h0BAD_0BAD);
        tick(); nop(); #1;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
